// File: rtl/uart_tx_periph_pkg.sv
// Shared types and constants for the memory-mapped UART transmitter.
package uart_tx_periph_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } tx_state_e;

    localparam logic [1:0] REG_TXDATA  = 2'd0;
    localparam logic [1:0] REG_STATUS  = 2'd1;
    localparam logic [1:0] REG_BAUDDIV = 2'd2;

    localparam int STAT_BUSY  = 0;
    localparam int STAT_FULL  = 1;
    localparam int STAT_EMPTY = 2;
    localparam int STAT_OVF   = 3;

    // Divisors below 2 would make a bit period shorter than the FSM can track.
    function automatic logic [15:0] eff_div(input logic [15:0] div);
        return (div < 16'd2) ? 16'd2 : div;
    endfunction

endpackage

// File: rtl/uart_tx_periph_if.sv
// Processor data-bus slice seen by the UART: chip enable, byte enables, word offset, data.
interface uart_tx_periph_if;
    logic        ce;
    logic [3:0]  wbe;
    logic [1:0]  address;
    logic [31:0] data_in;
    logic [31:0] data_out;

    modport master (output ce, wbe, address, data_in, input data_out);
    modport slave  (input ce, wbe, address, data_in, output data_out);
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with fall-through output; push on a full FIFO succeeds if a pop happens too.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    // NOTE: the storage array is deliberately not reset; pointers and count define validity.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

endmodule

// File: rtl/uart_tx_periph.sv
// Memory-mapped UART transmitter: register decode, TX FIFO and 8N1 serializer.
module uart_tx_periph
    import uart_tx_periph_pkg::*;
#(
    parameter int CLK_HZ     = 25000000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    uart_tx_periph_if.slave bus,
    output logic            tx
);
    localparam logic [15:0] DIV_RST = 16'(CLK_HZ / BAUD);
    localparam int          CW      = $clog2(FIFO_DEPTH) + 1;

    logic          wr_en;
    logic          push;
    logic          pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic [7:0]    fifo_dout;
    logic [CW-1:0] fifo_count;
    logic [15:0]   baud_div;
    logic          overflow;

    tx_state_e     state;
    tx_state_e     state_d;
    logic [15:0]   bit_cnt;
    logic [15:0]   bit_cnt_d;
    logic [2:0]    bit_idx;
    logic [2:0]    bit_idx_d;
    logic [7:0]    shift_reg;
    logic [7:0]    shift_d;
    logic          tx_d;
    logic          bit_end;
    logic          unused_bits;

    assign wr_en       = bus.ce && (bus.wbe != 4'b0000);
    assign push        = wr_en && (bus.address == REG_TXDATA) && bus.wbe[0];
    assign bit_end     = (bit_cnt == 16'd0);
    assign unused_bits = ^{bus.data_in[31:16], fifo_count};

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .din   (bus.data_in[7:0]),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            baud_div <= DIV_RST;
            overflow <= 1'b0;
        end else begin
            if (wr_en && bus.address == REG_BAUDDIV) begin
                if (bus.wbe[0]) baud_div[7:0]  <= bus.data_in[7:0];
                if (bus.wbe[1]) baud_div[15:8] <= bus.data_in[15:8];
            end
            // A byte is only lost when the FIFO is full and nothing leaves it this cycle.
            if (push && fifo_full && !pop)
                overflow <= 1'b1;
            else if (wr_en && bus.address == REG_STATUS && bus.data_in[STAT_OVF])
                overflow <= 1'b0;
        end
    end

    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    always_comb begin
        bus.data_out = '0;
        if (bus.ce && bus.wbe == 4'b0000) begin
            unique case (bus.address)
                REG_STATUS: begin
                    bus.data_out[STAT_BUSY]  = (state != S_IDLE);
                    bus.data_out[STAT_FULL]  = fifo_full;
                    bus.data_out[STAT_EMPTY] = fifo_empty;
                    bus.data_out[STAT_OVF]   = overflow;
                end
                REG_BAUDDIV: bus.data_out[15:0] = baud_div;
                default:     bus.data_out = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            bit_cnt   <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
            tx        <= 1'b1;
        end else begin
            state     <= state_d;
            bit_cnt   <= bit_cnt_d;
            bit_idx   <= bit_idx_d;
            shift_reg <= shift_d;
            tx        <= tx_d;
        end
    end

    always_comb begin
        state_d = state;
        unique case (state)
            S_IDLE:  if (!fifo_empty) state_d = S_START;
            S_START: if (bit_end) state_d = S_DATA;
            S_DATA:  if (bit_end && bit_idx == 3'd7) state_d = S_STOP;
            S_STOP:  if (bit_end) state_d = fifo_empty ? S_IDLE : S_START;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are computed from the next state so tx leaves a register aligned with the state.
    always_comb begin
        pop       = 1'b0;
        bit_cnt_d = bit_cnt;
        bit_idx_d = bit_idx;
        shift_d   = shift_reg;
        tx_d      = 1'b1;

        if (state != S_IDLE && !bit_end)
            bit_cnt_d = bit_cnt - 16'd1;
        else if (state_d != S_IDLE)
            bit_cnt_d = eff_div(baud_div) - 16'd1;
        else
            bit_cnt_d = '0;

        if (state_d == S_START && state != S_START) begin
            pop       = 1'b1;
            shift_d   = fifo_dout;
            bit_idx_d = 3'd0;
        end else if (state == S_DATA && bit_end) begin
            shift_d   = {1'b0, shift_reg[7:1]};
            bit_idx_d = bit_idx + 3'd1;
        end

        unique case (state_d)
            S_START: tx_d = 1'b0;
            S_DATA:  tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
    end

endmodule
